// File: rtl/video_pattern_gen.sv
// video_pattern_gen: synthetic video source (sof/sop/eop/valid/data) with
// horizontal and vertical blanking and four selectable test patterns.
// Pattern selection and solid level are latched once per frame.
// Optional build macro VPG_NOISE_EN adds LFSR dither and one extra output stage.
module video_pattern_gen #(
  parameter int W        = 8,
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720,
  parameter int H_BLANK  = 370,
  parameter int V_BLANK  = 30
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [1:0]   pattern_sel,
  input  logic [W-1:0] solid_level,
  output logic         sof,
  output logic         sop,
  output logic         eop,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         busy
);

  // x/y must reach bit 6 for the checker tiles and bit W-1 for the ramps.
  localparam int XC     = $clog2(H_ACTIVE);
  localparam int XW0    = (XC > 7) ? XC : 7;
  localparam int XW     = (XW0 > W) ? XW0 : W;
  localparam int YC     = $clog2(V_ACTIVE);
  localparam int YW0    = (YC > 7) ? YC : 7;
  localparam int YW     = (YW0 > W) ? YW0 : W;
  localparam int VB_CYC = V_BLANK * (H_ACTIVE + H_BLANK);
  localparam int BMAX   = (VB_CYC > H_BLANK) ? VB_CYC : H_BLANK;
  localparam int BW     = $clog2(BMAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_ACTIVE, S_HBLANK, S_VBLANK, S_FEND} state_t;

  state_t        state, state_nx;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [BW-1:0] bcnt;
  logic [1:0]    pat;
  logic [W-1:0]  lvl;
  logic          x_last, y_last, h_last, v_last, latch;

  logic          pix_valid, pix_sop, pix_eop, pix_sof, busy_nx;
  logic [W-1:0]  pix_data;

  // first-stage registered stream
  logic          v1, sop1, eop1, sof1;
  logic [W-1:0]  d1;

  assign x_last = (x == XW'(H_ACTIVE - 1));
  assign y_last = (y == YW'(V_ACTIVE - 1));
  assign h_last = (bcnt == BW'(H_BLANK - 1));
  assign v_last = (bcnt == BW'(VB_CYC - 1));
  assign latch  = enable && (state == S_IDLE || state == S_FEND);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic: line/frame sequencing
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (enable) state_nx = S_ACTIVE;
      S_ACTIVE: if (x_last) state_nx = S_HBLANK;
      S_HBLANK: if (h_last) begin
                  if (!y_last)          state_nx = S_ACTIVE;
                  else if (V_BLANK > 0) state_nx = S_VBLANK;
                  else                  state_nx = S_FEND;
                end
      S_VBLANK: if (v_last) state_nx = S_FEND;
      S_FEND:   state_nx = enable ? S_ACTIVE : S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Output decode: pixel flags and pattern value from the registered x/y
  always_comb begin
    pix_valid = (state == S_ACTIVE);
    pix_sop   = pix_valid && (x == '0);
    pix_eop   = pix_valid && x_last;
    pix_sof   = pix_sop && (y == '0);
    busy_nx   = (state_nx == S_ACTIVE) || (state_nx == S_HBLANK) || (state_nx == S_VBLANK);
    case (pat)
      2'd0:    pix_data = x[W-1:0];
      2'd1:    pix_data = y[W-1:0];
      2'd2:    pix_data = lvl;
      default: pix_data = (x[6] ^ y[6]) ? lvl : '0;
    endcase
  end

  // Position and blanking counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x    <= '0;
      y    <= '0;
      bcnt <= '0;
    end else begin
      if (state == S_ACTIVE) x <= x_last ? '0 : x + XW'(1);
      else                   x <= '0;
      if ((state == S_HBLANK && !h_last) || (state == S_VBLANK && !v_last))
        bcnt <= bcnt + BW'(1);
      else
        bcnt <= '0;
      if (state == S_HBLANK && h_last && !y_last)  y <= y + YW'(1);
      else if (state == S_FEND || state == S_IDLE) y <= '0;
    end
  end

  // Per-frame latch of pattern configuration
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat <= '0;
      lvl <= '0;
    end else if (latch) begin
      pat <= pattern_sel;
      lvl <= solid_level;
    end
  end

  // First output stage; data forced to 0 outside active pixels
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1   <= 1'b0;
      sop1 <= 1'b0;
      eop1 <= 1'b0;
      sof1 <= 1'b0;
      d1   <= '0;
      busy <= 1'b0;
    end else begin
      v1   <= pix_valid;
      sop1 <= pix_sop;
      eop1 <= pix_eop;
      sof1 <= pix_sof;
      d1   <= pix_valid ? pix_data : '0;
      busy <= busy_nx;
    end
  end

`ifdef VPG_NOISE_EN
  logic [15:0]  lfsr;
  logic [W-1:0] noisy;
  int           sum;

  // Dithered value: pattern + lfsr[3:0] - 8, clamped to the data range
  always_comb begin
    sum = int'(d1) + int'(lfsr[3:0]) - 8;
    if (sum < 0)                 noisy = '0;
    else if (sum > (2**W) - 1)   noisy = '1;
    else                         noisy = sum[W-1:0];
  end

  // LFSR: reseeded at each frame latch, one step per emitted pixel
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      lfsr <= 16'hACE1;
    else if (latch) lfsr <= 16'hACE1;
    else if (v1)    lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  // Second output stage keeps all stream signals aligned
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      sop   <= 1'b0;
      eop   <= 1'b0;
      sof   <= 1'b0;
      data  <= '0;
    end else begin
      valid <= v1;
      sop   <= sop1;
      eop   <= eop1;
      sof   <= sof1;
      data  <= v1 ? noisy : '0;
    end
  end
`else
  assign valid = v1;
  assign sop   = sop1;
  assign eop   = eop1;
  assign sof   = sof1;
  assign data  = d1;
`endif

endmodule

// File: tb/tb_video_pattern_gen.sv
// Scoreboard bench for video_pattern_gen using a reduced frame geometry.
module tb_video_pattern_gen;
  localparam int W    = 6;
  localparam int HA   = 80;
  localparam int VA   = 70;
  localparam int HB   = 10;
  localparam int VB   = 2;
  localparam int LINE = HA + HB;
  localparam int FRM  = (VA + VB) * LINE;
`ifdef VPG_NOISE_EN
  localparam int LAT = 2;
  localparam bit NOISE = 1'b1;
`else
  localparam int LAT = 1;
  localparam bit NOISE = 1'b0;
`endif

  typedef struct packed {
    logic         sof;
    logic         sop;
    logic         eop;
    logic [W-1:0] data;
  } px_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b0;
  logic [1:0]   pattern_sel = '0;
  logic [W-1:0] solid_level = '0;
  logic         sof, sop, eop, valid, busy;
  logic [W-1:0] data;

  video_pattern_gen #(.W(W), .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .V_BLANK(VB)) dut (
    .clk(clk), .reset(reset), .enable(enable), .pattern_sel(pattern_sel),
    .solid_level(solid_level), .sof(sof), .sop(sop), .eop(eop), .valid(valid),
    .data(data), .busy(busy)
  );

  always #5 clk = ~clk;

  px_t exp_q[$];
  int  n_vec = 0, n_err = 0;
  int  phase = 0;     // 0: reset only, 1: quiet, 2: scoreboard, 3: final
  int  n_tmo = 0, tmo_seen = 0;
  bit  done = 0;

  // expected stream for one frame
  task automatic push_frame(input int p, input int lv);
    logic [15:0] l;
    int v;
    px_t e;
    l = 16'hACE1;
    for (int yy = 0; yy < VA; yy++)
      for (int xx = 0; xx < HA; xx++) begin
        case (p)
          0:       v = xx % 64;
          1:       v = yy % 64;
          2:       v = lv;
          default: v = (((xx / 64) + (yy / 64)) % 2 == 1) ? lv : 0;
        endcase
        if (NOISE) begin
          v = v + int'(l[3:0]) - 8;
          if (v < 0) v = 0;
          if (v > 63) v = 63;
          l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
        end
        e.sof  = (xx == 0 && yy == 0);
        e.sop  = (xx == 0);
        e.eop  = (xx == HA - 1);
        e.data = W'(v);
        exp_q.push_back(e);
      end
  endtask

  task automatic wait_busy(input logic lvl, input int lim, output bit ok);
    logic prev;
    ok = 0;
    prev = busy;
    for (int i = 0; i < lim && !ok; i++) begin
      @(negedge clk);
      if (busy === lvl && prev !== lvl) ok = 1;
      prev = busy;
    end
    if (!ok) begin
      $display("FAIL busy_edge_timeout: got no busy=%0b edge within %0d cycles, required one", lvl, lim);
      n_tmo++;
    end
  endtask

  // ---------------- monitor / checker ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  logic bprev = 0;
  int brun = 0, eops = 0, sofs = 0, vrun = 0, irun = 0, fidx = 0, mx = 0, my = 0;
  px_t e;

  always @(negedge clk) begin
    if (n_tmo != tmo_seen) begin
      tmo_seen++;
      n_vec++;
      n_err++;
    end
    if (reset || phase == 1) begin
      chk("zero_outputs", 32'({sof, sop, eop, valid, busy, data}), 32'd0);
    end else if (phase >= 2) begin
      if (busy) brun++;
      if (!busy && bprev) begin
        chk("busy_cycles", brun, FRM);
        chk("eops_per_frame", eops, VA);
        chk("sofs_per_frame", sofs, 1);
        brun = 0; eops = 0; sofs = 0;
      end
      bprev = busy;
      if (valid) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL pixel_unexpected: got valid pixel, expected none queued");
        end else begin
          e = exp_q.pop_front();
          chk("pixel", 32'({sof, sop, eop, data}), 32'(e));
        end
        if (sof) begin
          sofs++; fidx++; mx = 0; my = 0;
          chk("first_valid_latency", brun, LAT + 1);
        end else if (sop) begin
          chk("hblank_gap", irun, HB);
          mx = 0; my++;
        end else mx++;
        vrun++;
        if (eop) begin
          chk("line_length", vrun, HA);
          vrun = 0; irun = 0; eops++;
        end
`ifndef VPG_NOISE_EN
        if (fidx == 1 && my == 0  && mx == 70) chk("ramp_x70_wrap", 32'(data), 32'd6);
        if (fidx == 1 && my == 40 && mx == 5)  chk("ramp_kept_after_sel_change", 32'(data), 32'd5);
        if (fidx == 2 && my == 0  && mx == 0)  chk("checker_0_0", 32'(data), 32'd0);
        if (fidx == 2 && my == 0  && mx == 64) chk("checker_64_0", 32'(data), 32'd50);
        if (fidx == 2 && my == 64 && mx == 64) chk("checker_64_64", 32'(data), 32'd0);
        if (fidx == 2 && my == 64 && mx == 63) chk("checker_63_64", 32'(data), 32'd50);
        if (fidx == 3 && my == 69 && mx == 10) chk("vramp_y69_wrap", 32'(data), 32'd5);
        if (fidx == 3 && my == 0  && mx == 79) chk("vramp_y0", 32'(data), 32'd0);
        if (fidx == 4 && my == 69 && mx == 79) chk("solid_last_pixel", 32'(data), 32'd63);
`endif
      end else begin
        irun++;
        chk("idle_flags", 32'({sof, sop, eop, data}), 32'd0);
      end
      if (phase == 3 && !done) begin
        chk("queue_drained", exp_q.size(), 0);
        chk("frame_count", fidx, 4);
        done = 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit ok;
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    enable = 1;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = (valid === 1'b1);
    end
    if (!ok) begin
      $display("FAIL first_line_timeout: got no valid within 20 cycles, required one");
      n_tmo++;
    end
    repeat (20) @(negedge clk);
    @(posedge clk);
    #2 reset = 1;
    enable = 0;
    repeat (3) @(negedge clk);
    reset = 0;
    phase = 1;
    repeat (100) @(negedge clk);
    phase = 2;

    // frame A: horizontal ramp; selection changes mid-frame
    pattern_sel = 2'd0; solid_level = 6'd0; enable = 1;
    wait_busy(1'b1, 20, ok);
    if (ok) push_frame(0, 0);
    repeat (30 * LINE) @(negedge clk);
    pattern_sel = 2'd3; solid_level = 6'd50;

    // frame B: checker, back-to-back
    wait_busy(1'b1, FRM + 20, ok);
    if (ok) push_frame(3, 50);
    pattern_sel = 2'd1; solid_level = 6'd7;

    // frame C: vertical ramp; enable dropped right after it starts
    wait_busy(1'b1, FRM + 20, ok);
    if (ok) push_frame(1, 7);
    enable = 0;
    wait_busy(1'b0, FRM + 20, ok);
    repeat (30) @(negedge clk);

    // frame D: solid at full scale, single frame
    pattern_sel = 2'd2; solid_level = 6'd63; enable = 1;
    wait_busy(1'b1, 20, ok);
    if (ok) push_frame(2, 63);
    enable = 0; pattern_sel = 2'd0; solid_level = 6'd1;
    wait_busy(1'b0, FRM + 20, ok);
    repeat (30) @(negedge clk);

    phase = 3;
    for (int i = 0; i < 10 && !done; i++) @(negedge clk);
    if (!done) $display("FAIL final_checks: got not reached, expected reached");
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/video_pattern_gen.md
Name: video_pattern_gen

Overview:
- Generates a synthetic video stream (sop/eop/valid/data) in the same line/frame format that the stream-statistics blocks consume: 1280x720 active pixels, with horizontal and vertical blanking.
- Bench and in-system source for bring-up of the HDR pipeline; drives the stream input of downstream processing in place of the camera path.
- Selectable test patterns; patterns are latched per frame so every frame is self-consistent.

Parameters:
- W, 8, pixel data width.
- H_ACTIVE, 1280, active pixels per line.
- V_ACTIVE, 720, active lines per frame.
- H_BLANK, 370, idle cycles after each line's last pixel (>=1).
- V_BLANK, 30, blank line periods after last active line (>=0); each period is H_ACTIVE+H_BLANK cycles.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  run request; level-sensitive.
- pattern_sel  in  2  0=horizontal ramp, 1=vertical ramp, 2=solid, 3=checkerboard.
- solid_level  in  W  value for pattern 2 and the checker "high" tile.
- sof  out  1  one-cycle pulse coincident with the first sop of a frame.
- sop  out  1  first valid pixel of a line.
- eop  out  1  last valid pixel of a line.
- valid  out  1  pixel qualifier.
- data  out  W  pixel value, meaningful only when valid=1.
- busy  out  1  high from frame start until the end of that frame's vertical blank.

Behaviour:
- Reset (async, active-high): FSM=IDLE; all outputs 0; x/y counters 0; latched pattern 0.
- FSM states:
  - IDLE: outputs 0. If enable=1, latch pattern_sel and solid_level, set busy=1, go to ACTIVE next cycle.
  - ACTIVE: valid=1 for exactly H_ACTIVE consecutive cycles; x counts 0..H_ACTIVE-1; no gaps inside a line.
    - sop=1 at x=0; eop=1 at x=H_ACTIVE-1; sof=1 at x=0,y=0.
    - After eop go to HBLANK.
  - HBLANK: valid/sop/eop=0 for H_BLANK cycles. Then:
    - if y<V_ACTIVE-1: y++, go to ACTIVE;
    - else, if V_BLANK>0: go to VBLANK;
    - else: go to frame end.
  - VBLANK: counts V_BLANK*(H_ACTIVE+H_BLANK) idle cycles, then goes to frame end.
  - Frame end:
    - busy deasserts for 1 cycle and y resets to 0.
    - If enable=1: relatch pattern_sel/solid_level and go to ACTIVE. Back-to-back frames have a 1-cycle gap beyond blanking.
    - Otherwise go to IDLE.
- enable deasserted mid-frame: current frame completes in full, including vertical blank. Never truncate a line or frame.
- pattern_sel/solid_level changes mid-frame: ignored until the next frame latch.
- Pattern data, combinational from registered x/y; data registered, aligned with valid:
  - 0: data = x[W-1:0] (wraps every 2^W pixels).
  - 1: data = y[W-1:0].
  - 2: data = solid_level.
  - 3: data = (x[6]^y[6]) ? solid_level : 0 (64x64 tiles).
- Latency: the first valid follows the IDLE->ACTIVE transition by exactly 1 cycle; sop/eop/sof/valid/data are all registered outputs with no relative skew.
- Counter widths: x >= clog2(H_ACTIVE), y >= clog2(V_ACTIVE); blank counters sized for the largest count. No wrap inside legal ranges.
- data is driven 0 whenever valid=0.

Optional Feature:
- Macro: VPG_NOISE_EN.
- Defined:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11, seeded 16'hACE1 at each frame latch; advances once per valid pixel.
  - data = saturate(pattern + lfsr[3:0] - 8) to [0, 2^W-1].
  - Adds one pipeline stage: valid/sop/eop/sof/data are all delayed together by 1 cycle.
- Undefined: no LFSR logic; data is the exact pattern; latency as above.

Test Plan:
- Reset check: assert reset mid-line with valid=1 -> all outputs 0 in the same cycle; after release with enable=0, outputs stay 0 for 100 cycles.
- Line timing: enable=1, pattern 0 -> 1280 consecutive valid cycles per line, sop at x=0 and eop at x=1279; 370 idle cycles between eop and next sop; data at x=300 equals 44.
- Frame timing: run one frame with enable=1 then drop enable -> exactly 720 eops; one sof; busy high for 720*1650 + 30*1650 cycles; then IDLE with busy=0.
- Mid-frame pattern change: switch pattern_sel 0->3 at line 100 -> frame remains ramp. The next frame is checker with solid_level=200: pixel (64,0)=200 and pixel (64,64)=0.
- Vertical ramp statistics: pattern 1 -> line 719 data=207 on every pixel; line 256 data=0; per-frame min 0, max 255.
- VPG_NOISE_EN: pattern 2, solid_level=0 -> no data below 0 (saturation); solid_level=255 -> none above 255. First-pixel data reproducible frame to frame from seed 16'hACE1.
